// File: rtl/systolic_host_dma_pkg.sv
// Shared address map, CTRL start-bit position and the host DMA sequencer states.
package systolic_host_dma_pkg;

   localparam logic [15:0] A_BASE   = 16'h0000;
   localparam logic [15:0] B_BASE   = 16'h0100;
   localparam logic [15:0] CTRL_ADR = 16'h0200;
   localparam logic [15:0] STAT_ADR = 16'h0201;
   localparam logic [15:0] RES_BASE = 16'h0300;

   localparam int CTRL_START_BIT = 15;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_KICK,
      S_POLL_RD,
      S_POLL_WT,
      S_UNLOAD_RD,
      S_UNLOAD_WT,
      S_END
   } state_e;

endpackage

// File: rtl/systolic_host_dma_res_skid.sv
// One-entry result holding register between the array read port and the result stream.
module sys_res_skid #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         drain_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign drain_o = valid_q && ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = load_data_i;
      end else if (drain_o) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/systolic_host_dma.sv
// Host-side DMA sequencer: loads A/B operands into the systolic array RAM, kicks it,
// polls status and unloads results through a one-entry holding register.
//
// state     | meaning
// IDLE      | waiting for go
// LOAD_A    | streaming 4*job_len operand words to A_BASE
// LOAD_B    | streaming 4*job_len operand words to B_BASE
// KICK      | single CTRL write with the start bit and job_len
// POLL_RD   | STAT read issued
// POLL_WT   | STAT data returned, decide done / retry / timeout
// UNLOAD_RD | result read issued once the holding register can accept
// UNLOAD_WT | result data captured into the holding register
// END       | waiting for the last result to drain
module systolic_host_dma
   import systolic_host_dma_pkg::*;
#(
   parameter int POLL_LIMIT = 1024,
   parameter int RES_WORDS  = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        go_i,
   input  logic [7:0]  job_len_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   input  logic        src_valid_i,
   output logic        src_ready_o,
   input  logic [15:0] src_data_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [15:0] res_data_o,
   output logic        ren_o,
   output logic [15:0] ibus_radr_o,
   output logic        wen_o,
   output logic [15:0] ibus_wadr_o,
   output logic [15:0] ibus_wdata_o,
   input  logic [15:0] ibus_rdata_i
);

   localparam int PW = $clog2(POLL_LIMIT + 1);

   state_e          state_q, state_d;
   logic [9:0]      cnt_q, cnt_d;
   logic [PW-1:0]   poll_q, poll_d;
   logic [7:0]      len_q, len_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            skid_load, skid_valid, skid_drain;
   logic [9:0]      cnt_inc, load_words;

   assign cnt_inc    = cnt_q + 10'd1;
   assign load_words = {len_q, 2'b00};
   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign res_valid_o = skid_valid;

   sys_res_skid #(.W(16)) u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (skid_load),
      .load_data_i (ibus_rdata_i),
      .ready_i     (res_ready_i),
      .valid_o     (skid_valid),
      .data_o      (res_data_o),
      .drain_o     (skid_drain)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      poll_d       = poll_q;
      len_d        = len_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      skid_load    = 1'b0;
      src_ready_o  = 1'b0;
      ren_o        = 1'b0;
      ibus_radr_o  = '0;
      wen_o        = 1'b0;
      ibus_wadr_o  = '0;
      ibus_wdata_o = '0;
      case (state_q)
         S_IDLE: begin
            if (go_i) begin
               if (job_len_i != 8'd0) begin
                  len_d   = job_len_i;
                  cnt_d   = '0;
                  state_d = S_LOAD_A;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            src_ready_o = 1'b1;
            if (src_valid_i) begin
               wen_o        = 1'b1;
               ibus_wadr_o  = ((state_q == S_LOAD_A) ? A_BASE : B_BASE) + 16'(cnt_q);
               ibus_wdata_o = src_data_i;
               if (cnt_inc == load_words) begin
                  cnt_d   = '0;
                  state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_KICK;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_KICK: begin
            wen_o        = 1'b1;
            ibus_wadr_o  = CTRL_ADR;
            ibus_wdata_o = (16'd1 << CTRL_START_BIT) | {8'd0, len_q};
            poll_d       = '0;
            state_d      = S_POLL_RD;
         end
         S_POLL_RD: begin
            ren_o       = 1'b1;
            ibus_radr_o = STAT_ADR;
            state_d     = S_POLL_WT;
         end
         S_POLL_WT: begin
            if (ibus_rdata_i[0]) begin
               cnt_d   = '0;
               state_d = S_UNLOAD_RD;
            end else if (poll_q < PW'(POLL_LIMIT)) begin
               poll_d  = poll_q + 1'b1;
               state_d = S_POLL_RD;
            end else begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_UNLOAD_RD: begin
            // Only fetch when the holding register will be free at capture time.
            if (!skid_valid || skid_drain) begin
               ren_o       = 1'b1;
               ibus_radr_o = RES_BASE + 16'(cnt_q);
               state_d     = S_UNLOAD_WT;
            end
         end
         S_UNLOAD_WT: begin
            skid_load = 1'b1;
            cnt_d     = cnt_inc;
            state_d   = (cnt_inc == 10'(RES_WORDS)) ? S_END : S_UNLOAD_RD;
         end
         S_END: begin
            if (!skid_valid) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         poll_q  <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         poll_q  <= poll_d;
         len_q   <= len_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_systolic_host_dma.sv
// Directed-plus-random bench for systolic_host_dma against a transaction-level model of the job.
module tb_systolic_host_dma;

   localparam int PL = 4;
   localparam int RW = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        go = 1'b0;
   logic [7:0]  job_len = 8'd0;
   logic        busy, done, err;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [15:0] src_data = 16'd0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic        ren, wen;
   logic [15:0] radr, wadr, wdata;
   logic [15:0] rdata = 16'd0;

   systolic_host_dma #(.POLL_LIMIT(PL), .RES_WORDS(RW)) dut (
      .clk_i(clk), .rst_i(rst), .go_i(go), .job_len_i(job_len),
      .busy_o(busy), .done_o(done), .err_o(err),
      .src_valid_i(src_valid), .src_ready_o(src_ready), .src_data_i(src_data),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
      .ren_o(ren), .ibus_radr_o(radr), .wen_o(wen), .ibus_wadr_o(wadr),
      .ibus_wdata_o(wdata), .ibus_rdata_i(rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] wr_q[$];
   logic [15:0] rd_q[$];
   logic [15:0] res_q[$];
   logic [15:0] src_words[$];
   logic [15:0] res_mem[RW];
   int          stat_reads = 0;
   int          stat_at = 0;
   int          ready_mode = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          viol = 0;
   int          rcyc = 0;
   logic [15:0] nxt_rdata = 16'd0;
   logic        hold_flag = 1'b0;
   logic [15:0] hold_data = 16'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus monitor, result sink and RAM responder, all sampled mid-cycle.
   always @(negedge clk) begin
      if (ren && wen) viol++;
      if (!ren && radr !== 16'd0) viol++;
      if (!wen && (wadr !== 16'd0 || wdata !== 16'd0)) viol++;
      if (done && err) viol++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (wen) wr_q.push_back({wadr, wdata});
      nxt_rdata = 16'($urandom);
      if (ren) begin
         rd_q.push_back(radr);
         if (radr == 16'h0201) begin
            stat_reads++;
            nxt_rdata = (nxt_rdata & 16'hFFFE) |
                        16'((stat_at != 0 && stat_reads >= stat_at) ? 1 : 0);
         end else if (radr >= 16'h0300 && radr < 16'h0300 + RW) begin
            nxt_rdata = res_mem[radr - 16'h0300];
         end
      end
      if (rst) hold_flag = 1'b0;
      else begin
         if (hold_flag && (!res_valid || res_data !== hold_data)) viol++;
         if (res_valid && res_ready) res_q.push_back(res_data);
         hold_flag = res_valid && !res_ready;
         hold_data = res_data;
      end
   end

   always @(posedge clk) begin
      #1;
      rdata = nxt_rdata;
      rcyc++;
      case (ready_mode)
         0: res_ready = 1'b1;
         1: res_ready = (rcyc % 3 == 0);
         default: res_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic drive_src(input bit gaps);
      int t;
      for (int i = 0; i < src_words.size(); i++) begin
         src_valid = 1'b0;
         src_data  = 16'd0;
         if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         src_valid = 1'b1;
         src_data  = src_words[i];
         t = 0;
         @(negedge clk);
         while (!src_ready && t < 200) begin @(negedge clk); t++; end
         check("src_ready_wait", 32'(t < 200), 32'd1);
         @(posedge clk); #1;
      end
      src_valid = 1'b0;
      src_data  = 16'd0;
   endtask

   task automatic clear_logs();
      wr_q.delete(); rd_q.delete(); res_q.delete(); src_words.delete();
      stat_reads = 0;
   endtask

   task automatic run_job(input int len, input int st_at, input int rmode,
                          input bit gaps, input bit seq, input bit busy_go);
      int d0, e0, t, n_stat;
      bit ok;
      logic [31:0] exp_w[$];
      logic [15:0] exp_r[$];
      clear_logs();
      stat_at    = st_at;
      ready_mode = rmode;
      for (int i = 0; i < RW; i++) res_mem[i] = 16'($urandom);
      for (int i = 0; i < 8 * len; i++) src_words.push_back(seq ? 16'(i + 1) : 16'($urandom));
      d0 = done_cnt; e0 = err_cnt;
      go = 1'b1; job_len = 8'(len);
      @(posedge clk); #1;
      go = busy_go; job_len = 8'd0;
      drive_src(gaps);
      go = 1'b0;
      t = 0;
      while (done_cnt == d0 && err_cnt == e0 && t < 3000) begin @(negedge clk); t++; end
      check("job_end_timeout", 32'(t < 3000), 32'd1);
      repeat (3) @(negedge clk);
      ok = (st_at != 0 && st_at <= PL + 1);
      n_stat = ok ? st_at : PL + 1;
      for (int i = 0; i < 4 * len; i++) exp_w.push_back({16'h0000 + 16'(i), src_words[i]});
      for (int i = 0; i < 4 * len; i++) exp_w.push_back({16'h0100 + 16'(i), src_words[4 * len + i]});
      exp_w.push_back({16'h0200, 16'h8000 + 16'(len)});
      for (int i = 0; i < n_stat; i++) exp_r.push_back(16'h0201);
      if (ok) for (int i = 0; i < RW; i++) exp_r.push_back(16'h0300 + 16'(i));
      check("done_pulses", 32'(done_cnt - d0), ok ? 32'd1 : 32'd0);
      check("err_pulses", 32'(err_cnt - e0), ok ? 32'd0 : 32'd1);
      check("busy_after", 32'(busy), 32'd0);
      check("write_count", 32'(wr_q.size()), 32'(exp_w.size()));
      for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++) check("write", wr_q[i], exp_w[i]);
      check("read_count", 32'(rd_q.size()), 32'(exp_r.size()));
      for (int i = 0; i < exp_r.size() && i < rd_q.size(); i++) check("read_adr", 32'(rd_q[i]), 32'(exp_r[i]));
      check("result_count", 32'(res_q.size()), ok ? 32'(RW) : 32'd0);
      if (ok) for (int i = 0; i < RW && i < res_q.size(); i++) check("result", 32'(res_q[i]), 32'(res_mem[i]));
      check("bus_protocol", 32'(viol), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int e0, d0;
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_outs", {27'd0, done, err, ren, wen, src_ready}, 32'd0);
      check("rst_bus", {radr, wadr | wdata}, 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic job, status ready on second poll
      run_job(1, 2, 0, 1'b0, 1'b1, 1'b0);

      // Zero-length reject
      clear_logs();
      e0 = err_cnt;
      go = 1'b1; job_len = 8'd0;
      @(posedge clk); #1;
      go = 1'b0;
      @(negedge clk);
      check("zero_len_err", 32'(err), 32'd1);
      check("zero_len_busy", 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
      check("zero_len_err_cnt", 32'(err_cnt - e0), 32'd1);
      check("zero_len_bus", 32'(wr_q.size() + rd_q.size()), 32'd0);
      @(posedge clk); #1;

      // Poll timeout
      run_job($urandom_range(1, 3), 0, 0, 1'b0, 1'b0, 1'b0);
      // Slow result consumer
      run_job(2, 1, 1, 1'b0, 1'b0, 1'b0);
      // Source gaps, random consumer, go held during the job
      run_job(3, 3, 2, 1'b1, 1'b0, 1'b1);

      // Reset during LOAD_B
      clear_logs();
      d0 = done_cnt; e0 = err_cnt;
      go = 1'b1; job_len = 8'd2;
      @(posedge clk); #1;
      go = 1'b0; job_len = 8'd0;
      for (int i = 0; i < 11; i++) src_words.push_back(16'($urandom));
      drive_src(1'b0);
      src_valid = 1'b1; src_data = 16'h5A5A;
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_outs", {27'd0, done, err, ren, wen, src_ready}, 32'd0);
      check("midrst_bus", {radr, wadr | wdata}, 32'd0);
      src_valid = 1'b0; src_data = 16'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      @(posedge clk); #1;
      run_job(2, 2, 2, 1'b1, 1'b0, 1'b0);

      for (int k = 0; k < 3; k++)
         run_job($urandom_range(1, 8), $urandom_range(1, 5), $urandom_range(0, 2), 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
